// File: rtl/lab_pkg.sv
//==============================================================================
// lab_pkg : shared state encoding and default pattern for the lab serial blocks
// Rev 1.0
//==============================================================================
`default_nettype none

package lab_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Reference stimulus for the lab sequence detectors, sent MSB first
  localparam logic [24:0] LAB_PATTERN = 25'b0010101101011100010101100;

endpackage : lab_pkg

`default_nettype wire

// File: rtl/serial_pattern_tx_if.sv
//==============================================================================
// serial_pattern_tx_if : load/control inputs and serial outputs of the pattern source
// Rev 1.0
//==============================================================================
`default_nettype none

interface serial_pattern_tx_if #(
  parameter int WIDTH = 25
) ();

  logic             load;
  logic [WIDTH-1:0] data_in;
  logic             loop;
  logic             stop;
  logic             x;
  logic             x_valid;
  logic             busy;
  logic             done;

  modport slave (
    input  load, data_in, loop, stop,
    output x, x_valid, busy, done
  );

  modport master (
    output load, data_in, loop, stop,
    input  x, x_valid, busy, done
  );

endinterface : serial_pattern_tx_if

`default_nettype wire

// File: rtl/bit_tick_gen.sv
//==============================================================================
// bit_tick_gen : clock divider marking the last clock of each DIV-clock bit period
// Rev 1.0
//==============================================================================
`default_nettype none

module bit_tick_gen #(
  parameter int DIV = 1
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic clr,
  input  wire logic en,
  output logic      tick
);

  localparam int                CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0]  c_last = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_div_cnt;
  logic             w_at_last;

  assign w_at_last = (r_div_cnt == c_last);
  assign tick      = en & w_at_last;

  // Held at zero outside a transfer so every new bit period starts aligned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
    end else if (clr || !en) begin
      r_div_cnt <= '0;
    end else if (w_at_last) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

endmodule : bit_tick_gen

`default_nettype wire

// File: rtl/serial_pattern_tx.sv
//==============================================================================
// serial_pattern_tx : MSB-first parallel-to-serial pattern source, one-shot or looping
// Rev 1.0
//==============================================================================
`default_nettype none

module serial_pattern_tx #(
  parameter int WIDTH = 25,
  parameter int DIV   = 1
) (
  input  wire logic          clk,
  input  wire logic          rst,
  serial_pattern_tx_if.slave bus
);

  import lab_pkg::*;

  localparam int               BC_W   = $clog2(WIDTH);
  localparam logic [BC_W-1:0]  c_last = BC_W'(WIDTH - 1);

  state_t            r_state,   w_state_n;
  logic [WIDTH-1:0]  r_shreg,   w_shreg_n;
  logic [BC_W-1:0]   r_bit_cnt, w_bit_cnt_n;
  logic              r_loop,    w_loop_n;
  logic              r_x,       w_x_n;
  logic              r_x_valid, w_x_valid_n;
  logic              r_busy,    w_busy_n;
  logic              r_done,    w_done_n;

  logic              w_accept;
  logic              w_tick;
  logic              w_last_bit;

  assign w_accept   = (r_state == IDLE) && bus.load;
  assign w_last_bit = (r_bit_cnt == c_last);

  bit_tick_gen #(
    .DIV (DIV)
  ) u_bit_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_accept),
    .en   (r_state == SHIFT),
    .tick (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_loop    <= 1'b0;
      r_x       <= 1'b0;
      r_x_valid <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_shreg   <= w_shreg_n;
      r_bit_cnt <= w_bit_cnt_n;
      r_loop    <= w_loop_n;
      r_x       <= w_x_n;
      r_x_valid <= w_x_valid_n;
      r_busy    <= w_busy_n;
      r_done    <= w_done_n;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_shreg_n   = r_shreg;
    w_bit_cnt_n = r_bit_cnt;
    w_loop_n    = r_loop;
    w_x_n       = r_x;
    w_x_valid_n = r_x_valid;
    w_busy_n    = r_busy;
    w_done_n    = 1'b0;

    case (r_state)
      IDLE: begin
        w_x_n       = 1'b0;
        w_x_valid_n = 1'b0;
        w_busy_n    = 1'b0;
        if (bus.load) begin
          w_state_n   = SHIFT;
          w_shreg_n   = bus.data_in;
          w_loop_n    = bus.loop;
          w_bit_cnt_n = '0;
          w_x_n       = bus.data_in[WIDTH-1];
          w_x_valid_n = 1'b1;
          w_busy_n    = 1'b1;
        end
      end

      SHIFT: begin
        if (w_tick) begin
          // One-shot completion takes priority over a coincident stop
          if (w_last_bit && !r_loop) begin
            w_state_n   = IDLE;
            w_x_n       = 1'b0;
            w_x_valid_n = 1'b0;
            w_busy_n    = 1'b0;
            w_done_n    = 1'b1;
          end else if (bus.stop) begin
            w_state_n   = IDLE;
            w_x_n       = 1'b0;
            w_x_valid_n = 1'b0;
            w_busy_n    = 1'b0;
          end else begin
            // After WIDTH rotations the register is the original word again,
            // so the wrap in loop mode needs no reload
            w_shreg_n   = {r_shreg[WIDTH-2:0], r_shreg[WIDTH-1]};
            w_bit_cnt_n = w_last_bit ? '0 : r_bit_cnt + 1'b1;
            w_x_n       = r_shreg[WIDTH-2];
          end
        end
      end

      default: begin
        w_state_n = IDLE;
      end
    endcase
  end

  assign bus.x       = r_x;
  assign bus.x_valid = r_x_valid;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;

endmodule : serial_pattern_tx

`default_nettype wire
